// File: rtl/rr_select_arbiter4_pkg.sv
// Shared types and constants for the four-channel round-robin select arbiter.
package rr_select_arbiter4_pkg;

    localparam int NCH  = 4;
    localparam int SELW = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] idx);
        return NCH'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_select_arbiter4_pick.sv
// Combinational round-robin picker: first set bit of req scanning ptr, ptr+1, ... mod 4.
module rr_pick4
    import rr_select_arbiter4_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] idx,
    output logic            found
);

    logic [SELW-1:0] cand;

    // NOTE: every output of an always_comb gets a default first so no path infers a latch.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        // Scanning from the farthest offset down lets the nearest requester win last.
        for (int i = NCH - 1; i >= 0; i--) begin
            cand = ptr + SELW'(i);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_select_arbiter4.sv
// Round-robin arbiter driving the 2-bit select of a downstream 4:1 mux, with burst grants.
// Optional macro ARB_LOCK_EN adds a `lock` input that suppresses burst-expiry release.
module rr_select_arbiter4
    import rr_select_arbiter4_pkg::*;
#(
    parameter int BURST = 1
) (
    input  logic            clk,
    input  logic            reset,
`ifdef ARB_LOCK_EN
    input  logic            lock,
`endif
    input  logic [NCH-1:0]  req,
    input  logic            ready,
    output logic [SELW-1:0] sel,
    output logic [NCH-1:0]  grant,
    output logic            valid
);

    state_t          state, state_n;
    logic [SELW-1:0] ptr, ptr_n, sel_n, pick_ptr, pick_idx;
    logic [NCH-1:0]  grant_n;
    logic            valid_n, pick_found;
    logic [3:0]      burst_cnt, cnt_n;
    logic [4:0]      cnt_inc;
    logic            burst_done, lock_hold, release_now;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            grant     <= '0;
            valid     <= 1'b0;
            burst_cnt <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            sel       <= sel_n;
            grant     <= grant_n;
            valid     <= valid_n;
            burst_cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        sel_n       = sel;
        grant_n     = grant;
        valid_n     = valid;
        cnt_n       = burst_cnt;
        release_now = 1'b0;
`ifdef ARB_LOCK_EN
        lock_hold   = lock;
`else
        lock_hold   = 1'b0;
`endif
        // On release the releasing channel becomes last priority.
        pick_ptr    = (state == BUSY) ? sel + SELW'(1) : ptr;
        cnt_inc     = {1'b0, burst_cnt} + 5'd1;
        burst_done  = (cnt_inc >= 5'(BURST));

        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n = BUSY;
                    sel_n   = pick_idx;
                    grant_n = onehot(pick_idx);
                    valid_n = 1'b1;
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                if (!req[sel]) begin
                    release_now = 1'b1;
                end else if (ready) begin
                    if (burst_done && !lock_hold) release_now = 1'b1;
                    else cnt_n = burst_done ? 4'(BURST) : cnt_inc[3:0];
                end

                if (release_now) begin
                    ptr_n = sel + SELW'(1);
                    cnt_n = '0;
                    if (pick_found) begin
                        sel_n   = pick_idx;
                        grant_n = onehot(pick_idx);
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        valid_n = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rr_select_arbiter4.sv
// Directed bench for rr_select_arbiter4: BURST=1 and BURST=3 instances, scoreboard of expected outputs.
module tb_rr_select_arbiter4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req1, req3;
    logic       ready1, ready3;
    logic [1:0] sel1, sel3;
    logic [3:0] grant1, grant3;
    logic       valid1, valid3;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        bit         which;
        bit         check_sel;
        logic [1:0] sel;
        logic [3:0] grant;
        logic       valid;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    rr_select_arbiter4 #(.BURST(1)) dut1 (
        .clk   (clk),
        .reset (reset),
`ifdef ARB_LOCK_EN
        .lock  (1'b0),
`endif
        .req   (req1),
        .ready (ready1),
        .sel   (sel1),
        .grant (grant1),
        .valid (valid1)
    );

    rr_select_arbiter4 #(.BURST(3)) dut3 (
        .clk   (clk),
        .reset (reset),
`ifdef ARB_LOCK_EN
        .lock  (1'b0),
`endif
        .req   (req3),
        .ready (ready3),
        .sel   (sel3),
        .grant (grant3),
        .valid (valid3)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input bit which, input bit check_sel,
                        input logic [1:0] s, input logic [3:0] g, input logic v);
        exp_t e;
        e.tag = tag; e.which = which; e.check_sel = check_sel;
        e.sel = s; e.grant = g; e.valid = v;
        sb.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        if (e.which) begin
            if (e.check_sel) check({e.tag, ".sel"}, {2'b00, sel3}, {2'b00, e.sel});
            check({e.tag, ".grant"}, grant3, e.grant);
            check({e.tag, ".valid"}, {3'b000, valid3}, {3'b000, e.valid});
        end else begin
            if (e.check_sel) check({e.tag, ".sel"}, {2'b00, sel1}, {2'b00, e.sel});
            check({e.tag, ".grant"}, grant1, e.grant);
            check({e.tag, ".valid"}, {3'b000, valid1}, {3'b000, e.valid});
        end
    endtask

    // Drive one instance, predict its outputs after the next edge, then compare 1 ns after it.
    task automatic step(input bit which, input logic [3:0] rq, input logic rd,
                        input logic [1:0] s, input logic [3:0] g, input logic v,
                        input bit check_sel, input string tag);
        if (which) begin
            req3 = rq; ready3 = rd; req1 = 4'b0000; ready1 = 1'b0;
        end else begin
            req1 = rq; ready1 = rd; req3 = 4'b0000; ready3 = 1'b0;
        end
        push(tag, which, check_sel, s, g, v);
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    initial begin
        reset  = 1'b1;
        req1   = 4'b1111;
        ready1 = 1'b0;
        req3   = 4'b0000;
        ready3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push("reset", 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0);
        pop_compare();
        reset = 1'b0;

        // First grant one cycle after reset release, from ptr=0.
        step(0, 4'b1111, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b1, "first_grant");

        // BURST=1 rotation with every channel requesting.
        step(0, 4'b1111, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1, "rot1");
        step(0, 4'b1111, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1, "rot2");
        step(0, 4'b1111, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1, "rot3");
        step(0, 4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, "rot0");

        // Reach ch2, then backpressure for five cycles.
        step(0, 4'b1111, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1, "to_ch1");
        step(0, 4'b1111, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1, "to_ch2");
        for (int i = 0; i < 5; i++)
            step(0, 4'b1111, 1'b0, 2'd2, 4'b0100, 1'b1, 1'b1, "backpressure");
        step(0, 4'b1111, 1'b1, 2'd3, 4'b1000, 1'b1, 1'b1, "bp_release");

        // Abandon on ch1 with no other requester, then idle with stray ready.
        step(0, 4'b1111, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, "to_ch0");
        step(0, 4'b1111, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1, "to_ch1b");
        step(0, 4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 1'b0, "abandon");
        step(0, 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, "idle_ready");
        // ptr=2 after abandoning ch1: scan 2,3 empty, wraps to ch0.
        step(0, 4'b0011, 1'b0, 2'd0, 4'b0001, 1'b1, 1'b1, "wrap_to_ch0");
        step(0, 4'b0011, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1, "rotate_pair");

        // Asynchronous reset mid-cycle while BUSY.
        #3;
        reset = 1'b1;
        #1;
        push("async_reset", 1'b0, 1'b1, 2'b00, 4'b0000, 1'b0);
        pop_compare();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(0, 4'b1110, 1'b0, 2'd1, 4'b0010, 1'b1, 1'b1, "post_reset_ptr0");

        // BURST=3 with a single requester: three transfers, then self re-grant.
        step(1, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, "b3_grant");
        step(1, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, "b3_xfer1");
        step(1, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, "b3_xfer2");
        step(1, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, "b3_regrant");
        // Competing request must wait until the burst of three completes.
        step(1, 4'b0011, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, "b3_hold1");
        step(1, 4'b0011, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, "b3_hold2");
        step(1, 4'b0011, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1, "b3_switch");
        step(1, 4'b0011, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1, "b3_ch1_burst");

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
